pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_pkg.sv | 13 +
 rtl/pipe_stage_skid_slot.sv | 50 +++++
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 tb/tb_pipe_stage_skid.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy states
// and default field widths.
package pipe_pkg;
  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 160;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One beat holding register. Clear drops valid and zeroes ctrl but keeps data;
// clear wins over load so a flush always empties the slot.
module pipe_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_vld,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);
  logic              vld_d, vld_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (clear) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (load) begin
      vld_d  = 1'b1;
      ctrl_d = d_ctrl;
      data_d = d_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign q_vld  = vld_q;
  assign q_ctrl = ctrl_q;
  assign q_data = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Two-slot skid pipeline stage: main slot drives the outputs, skid slot absorbs
// the beat accepted while downstream stalls, so in_ready is purely registered.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic              main_vld, skid_vld;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_src_data;
  logic              main_ld, main_clr, skid_ld, skid_clr;
  logic              accept, xfer;
  state_e            state;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Occupancy is fully encoded by the two slot valid bits.
  always_comb begin
    state = EMPTY;
    if (skid_vld)      state = FULL;
    else if (main_vld) state = ONE;
  end

  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  assign main_src_ctrl = (state == FULL) ? skid_ctrl : in_ctrl;
  assign main_src_data = (state == FULL) ? skid_data : in_data;

  always_comb begin
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        EMPTY: main_ld = accept;
        ONE: begin
          if (xfer) begin
            main_ld  = accept;
            main_clr = ~accept;
          end else begin
            skid_ld = accept;
          end
        end
        FULL: begin
          main_ld  = xfer;
          skid_clr = xfer;
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (main_ld),
    .clear  (main_clr),
    .d_ctrl (main_src_ctrl),
    .d_data (main_src_data),
    .q_vld  (main_vld),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_ld),
    .clear  (skid_clr),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_vld  (skid_vld),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

  // Saturating bubble counter: downstream ready but nothing to give it.
  always_comb begin
    cnt_d = cnt_q;
    if (!out_valid && out_ready && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: driver pushes accepted beats, a negedge
// monitor pops on every downstream transfer and checks stall stability.
module tb_pipe_stage_skid;
  localparam int CW = 16;
  localparam int DW = 160;
  localparam int NW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] bubble_cnt;

  int checks = 0;
  int failures = 0;
  beat_t sb[$];
  beat_t exp_b;
  logic prev_stall = 1'b0;
  logic [CW-1:0] prev_ctrl;
  logic [DW-1:0] prev_data;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .bubble_cnt (bubble_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, after the driver has settled inputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", DW'(out_valid), DW'(1));
        chk("stall_ctrl", DW'(out_ctrl), DW'(prev_ctrl));
        chk("stall_data", out_data, prev_data);
      end
      if (!out_valid) chk("idle_ctrl_zero", DW'(out_ctrl), '0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none", out_ctrl);
        end else begin
          exp_b = sb.pop_front();
          chk("beat_ctrl", DW'(out_ctrl), DW'(exp_b.c));
          chk("beat_data", out_data, exp_b.d);
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_ctrl  = out_ctrl;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    beat_t b;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    b.c = c;
    b.d = d;
    if (iv && in_ready && !fl) sb.push_back(b);
    @(posedge clk);
    #1;
    if (fl) sb.delete();
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_out_ctrl", DW'(out_ctrl), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_bubble", DW'(bubble_cnt), '0);
    rst_n = 1'b1;

    // Single beat, latency one
    drive(1'b1, 16'h00A5, DW'(16'h1234), 1'b1, 1'b0);
    chk("lat1_valid", DW'(out_valid), DW'(1));
    chk("lat1_ctrl", DW'(out_ctrl), DW'(16'h00A5));
    chk("lat1_data", out_data, DW'(16'h1234));
    chk("lat1_in_ready", DW'(in_ready), DW'(1));
    idle(1'b1, 2);
    chk("lat1_drained", DW'(out_valid), '0);

    // Fill to FULL while stalled, then drain in order
    drive(1'b1, 16'h000A, DW'(160'hAAAA), 1'b0, 1'b0);
    drive(1'b1, 16'h000B, DW'(160'hBBBB), 1'b0, 1'b0);
    chk("full_in_ready", DW'(in_ready), '0);
    chk("full_out_ctrl", DW'(out_ctrl), DW'(16'h000A));
    drive(1'b1, 16'h000C, DW'(160'hCCCC), 1'b0, 1'b0);
    chk("full_hold_ctrl", DW'(out_ctrl), DW'(16'h000A));
    idle(1'b1, 1);
    chk("drain1_ctrl", DW'(out_ctrl), DW'(16'h000B));
    chk("drain1_in_ready", DW'(in_ready), DW'(1));
    idle(1'b1, 1);
    chk("drain2_valid", DW'(out_valid), '0);
    chk("drain2_in_ready", DW'(in_ready), DW'(1));

    // Flush in FULL with in_valid high
    drive(1'b1, 16'h0011, DW'(160'h11), 1'b0, 1'b0);
    drive(1'b1, 16'h0022, DW'(160'h22), 1'b0, 1'b0);
    drive(1'b1, 16'h0033, DW'(160'h33), 1'b0, 1'b1);
    chk("flush_full_valid", DW'(out_valid), '0);
    chk("flush_full_ctrl", DW'(out_ctrl), '0);
    chk("flush_full_in_ready", DW'(in_ready), DW'(1));
    chk("flush_full_data_kept", out_data, DW'(160'h11));
    idle(1'b1, 2);
    // Flush in ONE with transfer and accept in the same cycle
    drive(1'b1, 16'h0044, DW'(160'h44), 1'b0, 1'b0);
    drive(1'b1, 16'h0055, DW'(160'h55), 1'b1, 1'b1);
    chk("flush_one_valid", DW'(out_valid), '0);
    idle(1'b1, 2);
    chk("flush_no_beat", DW'(sb.size()), '0);

    // Bubble counter counts then saturates
    do_reset();
    chk("bub_reset", DW'(bubble_cnt), '0);
    idle(1'b1, 5);
    chk("bub_five", DW'(bubble_cnt), DW'(5));
    idle(1'b0, 3);
    chk("bub_not_ready", DW'(bubble_cnt), DW'(5));
    idle(1'b1, 69995);
    chk("bub_saturate", DW'(bubble_cnt), DW'(16'hFFFF));

    // Asynchronous reset between edges while ONE
    do_reset();
    idle(1'b1, 3);
    drive(1'b1, 16'h0077, DW'(160'h77), 1'b0, 1'b0);
    chk("arst_pre_valid", DW'(out_valid), DW'(1));
    chk("arst_pre_bubble", DW'(bubble_cnt), DW'(3));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", DW'(out_valid), '0);
    chk("arst_bubble", DW'(bubble_cnt), '0);
    chk("arst_in_ready", DW'(in_ready), DW'(1));
    chk("arst_ctrl", DW'(out_ctrl), '0);
    chk("arst_data", out_data, '0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 16'h0088, DW'(160'h88), 1'b1, 1'b0);
    chk("post_rst_valid", DW'(out_valid), DW'(1));
    chk("post_rst_ctrl", DW'(out_ctrl), DW'(16'h0088));
    idle(1'b1, 2);

    // Random traffic, no flush
    for (int i = 0; i < 10000; i++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      drive(1'($urandom_range(0, 1)), CW'($urandom()), rd, 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(1'b1, 4);
    chk("rand_drained", DW'(sb.size()), '0);
    chk("rand_end_valid", DW'(out_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
